// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bundle between a memory initiator
// (fetch stage or bench) and the mem_responder word memory.
interface mem_responder_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int WORD_WIDTH = 32
);
  logic                  i_req;
  logic                  i_write;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [WORD_WIDTH-1:0] i_wdata;
  logic                  i_abort;
  logic                  o_busy;
  logic                  o_valid;
  logic [WORD_WIDTH-1:0] o_rdata;
  logic                  o_err;

  modport master (
    output i_req, i_write, i_addr, i_wdata, i_abort,
    input  o_busy, o_valid, o_rdata, o_err
  );

  modport slave (
    input  i_req, i_write, i_addr, i_wdata, i_abort,
    output o_busy, o_valid, o_rdata, o_err
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding word memory with programmable wait states.
// A request is captured in IDLE, waits LATENCY cycles, performs the access on
// the final wait edge and presents a one-cycle o_valid response.
// Optional feature macro: MEM_RESPONDER_ALIGN_CHECK_EN -- when defined, an
// access with addr[1:0] != 0 is refused (no write, zero data, o_err set);
// otherwise the low address bits are ignored and o_err is always 0.
module mem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int WORD_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  mem_responder_if.slave   bus
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << IDX_W;
  // The counter counts remaining wait cycles after the first one, so a
  // LATENCY of N yields exactly N cycles in WAIT.
  localparam logic [3:0] LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  write_q;
  logic [IDX_W-1:0]      idx_q;
  logic [WORD_WIDTH-1:0] wdata_q;
  logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q;
  logic                  mis_q;

  logic                  cap_en;
  logic                  acc_en;
  logic                  acc_write;
  logic [IDX_W-1:0]      acc_idx;
  logic [WORD_WIDTH-1:0] acc_wdata;
  logic                  acc_mis;
  logic                  mem_we;
  logic                  in_mis;

  logic [WORD_WIDTH-1:0] mem_q [DEPTH];

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  assign in_mis = |bus.i_addr[1:0];
`else
  // Byte lanes are not modelled: the low address bits select nothing.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus.i_addr[1:0];
  assign in_mis          = 1'b0;
`endif

  // Next-state, access selection and handshake outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_en      = 1'b0;
    acc_en      = 1'b0;
    acc_write   = write_q;
    acc_idx     = idx_q;
    acc_wdata   = wdata_q;
    acc_mis     = mis_q;
    bus.o_busy  = (state_q != ST_IDLE);
    bus.o_valid = (state_q == ST_RESP);

    case (state_q)
      ST_IDLE: begin
        if (bus.i_req) begin
          cap_en = 1'b1;
          if (LATENCY == 0) begin
            // Zero wait states: access straight from the request inputs.
            acc_en    = 1'b1;
            acc_write = bus.i_write;
            acc_idx   = bus.i_addr[ADDR_WIDTH-1:2];
            acc_wdata = bus.i_wdata;
            acc_mis   = in_mis;
            state_d   = ST_RESP;
          end else begin
            cnt_d   = LAT_LOAD;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Only reads may be cancelled; a write always lands.
        if (bus.i_abort && !write_q) begin
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          acc_en  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    mem_we  = acc_en && acc_write && !acc_mis;
    if (acc_mis)
      rdata_d = '0;
    else if (acc_write)
      rdata_d = acc_wdata;
    else
      rdata_d = mem_q[acc_idx];
  end

  assign bus.o_rdata = rdata_q;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  assign bus.o_err   = err_q && (state_q == ST_RESP);
`else
  assign bus.o_err   = 1'b0;
`endif

  // Control state and response registers, cleared by reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (acc_en) begin
        rdata_q <= rdata_d;
        err_q   <= acc_mis;
      end
    end
  end

  // Request capture in IDLE; reset wins over a simultaneous request
  always_ff @(posedge i_clk) begin
    if (!i_rst && cap_en) begin
      write_q <= bus.i_write;
      idx_q   <= bus.i_addr[ADDR_WIDTH-1:2];
      wdata_q <= bus.i_wdata;
      mis_q   <= in_mis;
    end
  end

  // Word array: not cleared by reset, and no write lands on a reset edge
  always_ff @(posedge i_clk) begin
    if (!i_rst && mem_we)
      mem_q[acc_idx] <= acc_wdata;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances (LATENCY 2, 0 and 3)
// share one clock and reset; 'sel' routes the stimulus to one of them.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          sel = 2;
  logic        req = 1'b0;
  logic        write = 1'b0;
  logic [11:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        abort = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_WIDTH(12), .WORD_WIDTH(32)) if2 ();
  mem_responder_if #(.ADDR_WIDTH(12), .WORD_WIDTH(32)) if0 ();
  mem_responder_if #(.ADDR_WIDTH(12), .WORD_WIDTH(32)) if3 ();

  assign if2.i_req   = (sel == 2) && req;
  assign if2.i_write = write;
  assign if2.i_addr  = addr;
  assign if2.i_wdata = wdata;
  assign if2.i_abort = (sel == 2) && abort;
  assign if0.i_req   = (sel == 0) && req;
  assign if0.i_write = write;
  assign if0.i_addr  = addr;
  assign if0.i_wdata = wdata;
  assign if0.i_abort = (sel == 0) && abort;
  assign if3.i_req   = (sel == 3) && req;
  assign if3.i_write = write;
  assign if3.i_addr  = addr;
  assign if3.i_wdata = wdata;
  assign if3.i_abort = (sel == 3) && abort;

  mem_responder #(.ADDR_WIDTH(12), .WORD_WIDTH(32), .LATENCY(2)) u_l2 (
    .i_clk(clk), .i_rst(rst), .bus(if2.slave));
  mem_responder #(.ADDR_WIDTH(12), .WORD_WIDTH(32), .LATENCY(0)) u_l0 (
    .i_clk(clk), .i_rst(rst), .bus(if0.slave));
  mem_responder #(.ADDR_WIDTH(12), .WORD_WIDTH(32), .LATENCY(3)) u_l3 (
    .i_clk(clk), .i_rst(rst), .bus(if3.slave));

  logic        cur_busy, cur_valid, cur_err;
  logic [31:0] cur_rdata;
  int          cur_lat;

  always_comb begin
    cur_busy  = if2.o_busy;
    cur_valid = if2.o_valid;
    cur_err   = if2.o_err;
    cur_rdata = if2.o_rdata;
    cur_lat   = 2;
    if (sel == 0) begin
      cur_busy = if0.o_busy; cur_valid = if0.o_valid;
      cur_err  = if0.o_err;  cur_rdata = if0.o_rdata; cur_lat = 0;
    end else if (sel == 3) begin
      cur_busy = if3.o_busy; cur_valid = if3.o_valid;
      cur_err  = if3.o_err;  cur_rdata = if3.o_rdata; cur_lat = 3;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction on the selected instance; checks busy while
  // waiting, response cycle, data, error flag and the single-cycle strobe.
  task automatic xact(input int d, input logic wr, input logic [11:0] a,
                      input logic [31:0] wd, input logic ab,
                      input logic [31:0] exp_rd, input logic exp_err,
                      input string tag);
    int k;
    sel = d; write = wr; addr = a; wdata = wd; req = 1'b1;
    @(negedge clk);
    req = 1'b0; abort = ab;
    k = 1;
    while (!cur_valid && k < 20) begin
      chk({tag, "_busy_wait"}, 32'(cur_busy), 32'd1);
      @(negedge clk);
      k++;
    end
    chk({tag, "_resp_cycle"}, 32'(k), 32'(cur_lat + 1));
    chk({tag, "_valid"}, 32'(cur_valid), 32'd1);
    chk({tag, "_busy_resp"}, 32'(cur_busy), 32'd1);
    chk({tag, "_rdata"}, cur_rdata, exp_rd);
    chk({tag, "_err"}, 32'(cur_err), 32'(exp_err));
    @(negedge clk);
    abort = 1'b0;
    chk({tag, "_valid_drop"}, 32'(cur_valid), 32'd0);
    chk({tag, "_idle"}, 32'(cur_busy), 32'd0);
  endtask

  initial begin
    // Reset with a simultaneous request: reset wins, nothing captured
    sel = 2; req = 1'b1; write = 1'b1; addr = 12'h000; wdata = 32'hFFFF_FFFF;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy",  32'(cur_busy),  32'd0);
    chk("rst_valid", 32'(cur_valid), 32'd0);
    chk("rst_rdata", cur_rdata,      32'd0);
    chk("rst_err",   32'(cur_err),   32'd0);
    chk("rst_busy_l0", 32'(if0.o_busy), 32'd0);
    chk("rst_busy_l3", 32'(if3.o_busy), 32'd0);
    rst = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("rst_nocapture", 32'(cur_busy), 32'd0);

    // Preload
    xact(2, 1'b1, 12'h000, 32'hF142_0000, 1'b0, 32'hF142_0000, 1'b0, "pre0");
    xact(2, 1'b1, 12'h004, 32'hF088_0000, 1'b0, 32'hF088_0000, 1'b0, "pre1");
    xact(2, 1'b1, 12'h008, 32'hD142_0000, 1'b0, 32'hD142_0000, 1'b0, "pre2");
    xact(2, 1'b1, 12'h00C, 32'hB140_0000, 1'b0, 32'hB140_0000, 1'b0, "pre3");
    xact(2, 1'b1, 12'h010, 32'h9008_0000, 1'b0, 32'h9008_0000, 1'b0, "pre4");
    xact(3, 1'b1, 12'h000, 32'hF142_0000, 1'b0, 32'hF142_0000, 1'b0, "pre3_0");

    // LATENCY=2 read
    xact(2, 1'b0, 12'h008, 32'h0, 1'b0, 32'hD142_0000, 1'b0, "rd008");

    // LATENCY=0 write then read-back
    xact(0, 1'b1, 12'h014, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, "l0_wr014");
    xact(0, 1'b0, 12'h014, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, "l0_rd014");

    // LATENCY=3 read aborted in WAIT
    sel = 3; write = 1'b0; addr = 12'h010; req = 1'b1;
    @(negedge clk);
    req = 1'b0; abort = 1'b1;
    chk("abort_busy_wait", 32'(cur_busy), 32'd1);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle",  32'(cur_busy),  32'd0);
    chk("abort_valid", 32'(cur_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_valid", 32'(cur_valid), 32'd0);
    end
    xact(3, 1'b0, 12'h000, 32'h0, 1'b0, 32'hF142_0000, 1'b0, "l3_rd000");

    // LATENCY=3 write at top address survives abort
    xact(3, 1'b1, 12'hFFC, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b0, "l3_wrFFC_abort");
    xact(3, 1'b0, 12'hFFC, 32'h0, 1'b0, 32'h1234_5678, 1'b0, "l3_rdFFC");

    // LATENCY=2 reset mid-WAIT with the request held and inputs changing
    sel = 2; write = 1'b0; addr = 12'h004; req = 1'b1;
    @(negedge clk);
    chk("rstw_busy1", 32'(cur_busy), 32'd1);
    addr = 12'h010; write = 1'b1; wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    chk("rstw_busy2", 32'(cur_busy), 32'd1);
    chk("rstw_held_valid", 32'(cur_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_busy",  32'(cur_busy),  32'd0);
    chk("rstw_valid", 32'(cur_valid), 32'd0);
    chk("rstw_rdata", cur_rdata,      32'd0);
    chk("rstw_err",   32'(cur_err),   32'd0);
    rst = 1'b0; req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstw_no_valid", 32'(cur_valid), 32'd0);
    end
    xact(2, 1'b0, 12'h010, 32'h0, 1'b0, 32'h9008_0000, 1'b0, "rstw_rd010");
    xact(2, 1'b0, 12'h004, 32'h0, 1'b0, 32'hF088_0000, 1'b0, "rstw_rd004");

    // Misaligned access
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    xact(2, 1'b0, 12'h006, 32'h0, 1'b0, 32'h0, 1'b1, "mis_rd006");
    xact(2, 1'b1, 12'h00A, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1, "mis_wr00A");
    xact(2, 1'b0, 12'h008, 32'h0, 1'b0, 32'hD142_0000, 1'b0, "mis_rd008");
`else
    xact(2, 1'b0, 12'h006, 32'h0, 1'b0, 32'hF088_0000, 1'b0, "mis_rd006");
    xact(2, 1'b0, 12'h00B, 32'h0, 1'b0, 32'hD142_0000, 1'b0, "mis_rd00B");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
